order_content_arbiter: RTL and testbench

ORDER_CONTENT_ARBITER -- requirements
Module: order_content_arbiter

---
 rtl/order_table_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 39 +++
 rtl/order_content_arbiter.sv | 100 ++++++++++
 tb/tb_order_content_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_table_pkg.sv
// Shared defaults and state encoding for the order table arbiter.
// Imported by the top and its arbiter sub-module.
package order_table_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 241;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant for the write and read requesters.
// The pointer favours write out of reset, then the port not granted last.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr,
   output logic gnt_rd
);
   logic prio_rd;

   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      if (en) begin
         unique case (1'b1)
            (req_wr && req_rd): begin
               gnt_wr = !prio_rd;
               gnt_rd = prio_rd;
            end
            (req_wr && !req_rd): gnt_wr = 1'b1;
            (!req_wr && req_rd): gnt_rd = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_rd <= 1'b0;
      end else if (gnt_wr) begin
         prio_rd <= 1'b1;
      end else if (gnt_rd) begin
         prio_rd <= 1'b0;
      end
   end
endmodule

// File: rtl/order_content_arbiter.sv
// Order table front end: zero-fills the RAM, then arbitrates one
// insert and one lookup requester onto a single-port RAM.
module order_content_arbiter
   import order_table_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              axis_aclk,
   input  logic              axis_resetn,
   input  logic              clear,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic              rd_vld,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              init_done
);
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state;
   logic [ADDR_W:0] cnt;
   logic            arb_en;
   logic            gnt_wr;
   logic            gnt_rd;

   // clear wins over any request in the same cycle
   assign arb_en  = (state == ST_RUN) && !clear;
   assign rd_data = rd_vld ? ram_dout : '0;

   rr_arbiter2 u_arb (
      .clk    (axis_aclk),
      .rst_n  (axis_resetn),
      .en     (arb_en),
      .req_wr (wr_req && !wr_ack),
      .req_rd (rd_req && !rd_ack),
      .gnt_wr (gnt_wr),
      .gnt_rd (gnt_rd)
   );

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state     <= ST_INIT;
         cnt       <= '0;
         wr_ack    <= 1'b0;
         rd_ack    <= 1'b0;
         rd_vld    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         init_done <= 1'b0;
      end else begin
         wr_ack <= 1'b0;
         rd_ack <= 1'b0;
         ram_we <= 1'b0;
         rd_vld <= rd_ack;
         unique case (state)
            ST_INIT: begin
               // top bit of cnt marks the last address as written
               if (clear) begin
                  cnt <= '0;
               end else if (!cnt[ADDR_W]) begin
                  ram_we   <= 1'b1;
                  ram_addr <= cnt[ADDR_W-1:0];
                  ram_din  <= '0;
                  cnt      <= cnt + CNT_ONE;
               end else begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
                  cnt       <= '0;
               end
            end
            ST_RUN: begin
               if (clear) begin
                  state     <= ST_INIT;
                  init_done <= 1'b0;
                  cnt       <= '0;
               end else if (gnt_wr) begin
                  ram_we   <= 1'b1;
                  ram_addr <= wr_addr;
                  ram_din  <= wr_data;
                  wr_ack   <= 1'b1;
               end else if (gnt_rd) begin
                  ram_addr <= rd_addr;
                  rd_ack   <= 1'b1;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_order_content_arbiter.sv
// Randomised bench for order_content_arbiter with a write-first RAM
// model and a scoreboard of expected table contents.
module tb_order_content_arbiter;
   localparam int AW = 12;
   localparam int DW = 241;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ack;
   logic          rd_vld;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;
   logic          init_done;

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] exp_mem [DEPTH];

   int n_chk = 0;
   int n_pass = 0;

   logic          prio_rd_m;
   logic          pred_w;
   logic          pred_r;
   logic          exp_vld;
   logic [DW-1:0] exp_rdat;

   always #5 clk = ~clk;

   order_content_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .axis_aclk   (clk),
      .axis_resetn (rst_n),
      .clear       (clear),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_ack      (rd_ack),
      .rd_vld      (rd_vld),
      .rd_data     (rd_data),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_we      (ram_we),
      .ram_dout    (ram_dout),
      .init_done   (init_done)
   );

   // single-port RAM, registered read, write-first
   always @(posedge clk) begin
      if (ram_we) begin
         ram[ram_addr] <= ram_din;
         ram_dout      <= ram_din;
      end else begin
         ram_dout <= ram[ram_addr];
      end
   end

   task automatic check(string tag, logic [255:0] got,
                        logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [255:0] t;
      t = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
      return t[DW-1:0];
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      logic [31:0] r;
      r = $urandom_range(0, 16);
      return (r == 16) ? AW'(DEPTH - 1) : r[AW-1:0];
   endfunction

   task automatic model_zero();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      pred_w  = 1'b0;
      pred_r  = 1'b0;
      exp_vld = 1'b0;
   endtask

   // expects 4096 ascending zero writes, then init_done
   task automatic init_check(string tag);
      int bad = 0;
      logic [31:0] a;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         a = i;
         if (ram_we !== 1'b1 || ram_addr !== a[AW-1:0] ||
             ram_din !== '0 || init_done !== 1'b0 ||
             wr_ack !== 1'b0 || rd_ack !== 1'b0 ||
             rd_vld !== 1'b0) bad++;
         wr_req  = (i < DEPTH - 64) ? 1'($urandom_range(0, 1)) : 1'b0;
         rd_req  = (i < DEPTH - 64) ? 1'($urandom_range(0, 1)) : 1'b0;
         wr_addr = rnd_addr();
         rd_addr = rnd_addr();
      end
      check({tag, "_seq"}, 256'(bad), 256'(0));
      tick();
      check({tag, "_done"}, 256'(init_done), 256'(1));
      check({tag, "_we0"}, 256'(ram_we), 256'(0));
      check({tag, "_addr"}, 256'(ram_addr), 256'(DEPTH - 1));
      model_zero();
   endtask

   task automatic run_random(int n);
      for (int c = 0; c < n; c++) begin
         logic ew, er;
         tick();
         check("r_wr_ack", 256'(wr_ack), 256'(pred_w));
         check("r_rd_ack", 256'(rd_ack), 256'(pred_r));
         check("r_rd_vld", 256'(rd_vld), 256'(exp_vld));
         check("r_rd_data", 256'(rd_data),
               exp_vld ? 256'(exp_rdat) : 256'(0));
         exp_vld = rd_ack;
         if (rd_ack) begin
            exp_rdat = exp_mem[rd_addr];
            check("r_rd_addr", 256'(ram_addr), 256'(rd_addr));
            check("r_rd_we", 256'(ram_we), 256'(0));
            rd_req = 1'b0;
         end
         if (wr_ack) begin
            check("r_wr_we", 256'(ram_we), 256'(1));
            check("r_wr_addr", 256'(ram_addr), 256'(wr_addr));
            check("r_wr_din", 256'(ram_din), 256'(wr_data));
            exp_mem[wr_addr] = wr_data;
            wr_req = 1'b0;
         end
         if (!wr_ack && !rd_ack)
            check("r_idle_we", 256'(ram_we), 256'(0));
         if (c < n - 6) begin
            if (!wr_req && $urandom_range(0, 2) != 0) begin
               wr_req  = 1'b1;
               wr_addr = rnd_addr();
               wr_data = rnd_data();
            end
            if (!rd_req && $urandom_range(0, 2) != 0) begin
               rd_req  = 1'b1;
               rd_addr = rnd_addr();
            end
         end
         ew = wr_req && !wr_ack;
         er = rd_req && !rd_ack;
         pred_w = ew && (!er || !prio_rd_m);
         pred_r = er && (!ew || prio_rd_m);
         if (pred_w) prio_rd_m = 1'b1;
         else if (pred_r) prio_rd_m = 1'b0;
      end
   endtask

   initial begin
      logic [DW-1:0] d;
      int bad;
      rst_n = 1'b0; clear = 1'b0;
      wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      prio_rd_m = 1'b0;
      model_zero();
      repeat (3) tick();
      check("rst_init_done", 256'(init_done), 256'(0));
      check("rst_ram_we", 256'(ram_we), 256'(0));
      check("rst_acks", 256'({wr_ack, rd_ack, rd_vld}), 256'(0));
      check("rst_ram_addr", 256'(ram_addr), 256'(0));
      check("rst_rd_data", 256'(rd_data), 256'(0));
      rst_n = 1'b1;
      init_check("init1");

      // directed write then read of the same address
      wr_req = 1'b1; wr_addr = 12'h012; wr_data = DW'(12'hABC);
      tick();
      check("d_wr_ack", 256'(wr_ack), 256'(1));
      check("d_wr_we", 256'(ram_we), 256'(1));
      check("d_wr_addr", 256'(ram_addr), 256'(12'h012));
      check("d_wr_din", 256'(ram_din), 256'(12'hABC));
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 12'h012;
      tick();
      check("d_rd_ack", 256'(rd_ack), 256'(1));
      check("d_rd_we", 256'(ram_we), 256'(0));
      check("d_rd_addr", 256'(ram_addr), 256'(12'h012));
      rd_req = 1'b0;
      tick();
      check("d_rd_vld", 256'(rd_vld), 256'(1));
      check("d_rd_data", 256'(rd_data), 256'(12'hABC));
      tick();
      check("d_rd_vld0", 256'(rd_vld), 256'(0));
      check("d_rd_data0", 256'(rd_data), 256'(0));
      exp_mem[12'h012] = DW'(12'hABC);
      prio_rd_m = 1'b0;

      run_random(600);

      // clear coincident with a read request
      rd_req = 1'b1; rd_addr = 12'h003; clear = 1'b1;
      tick();
      check("c_rd_ack", 256'(rd_ack), 256'(0));
      check("c_init_done", 256'(init_done), 256'(0));
      check("c_we", 256'(ram_we), 256'(0));
      clear = 1'b0; rd_req = 1'b0;
      init_check("init2");
      run_random(600);

      // reset during an in-flight read
      rd_req = 1'b1; rd_addr = 12'h007;
      tick();
      check("x_rd_ack", 256'(rd_ack), 256'(1));
      rd_req = 1'b0;
      rst_n = 1'b0;
      #1;
      check("x_outs", 256'({wr_ack, rd_ack, rd_vld, ram_we, init_done}),
            256'(0));
      check("x_ram_addr", 256'(ram_addr), 256'(0));
      check("x_ram_din", 256'(ram_din), 256'(0));
      check("x_rd_data", 256'(rd_data), 256'(0));
      bad = 0;
      repeat (3) begin
         tick();
         if (rd_vld !== 1'b0) bad++;
      end
      check("x_no_vld", 256'(bad), 256'(0));
      rst_n = 1'b1;
      prio_rd_m = 1'b0;
      init_check("init3");

      // both requesters held: W,R,W,R...
      d = rnd_data();
      wr_req = 1'b1; wr_addr = 12'h005; wr_data = d;
      rd_req = 1'b1; rd_addr = 12'h006;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("alt", 256'({wr_ack, rd_ack}),
               (k % 2 == 0) ? 256'(2'b10) : 256'(2'b01));
      end
      wr_req = 1'b0; rd_req = 1'b0;
      tick();
      check("alt_vld", 256'(rd_vld), 256'(1));
      check("alt_data", 256'(rd_data), 256'(0));
      exp_mem[12'h005] = d;
      prio_rd_m = 1'b0;

      // last address of the zero-fill
      rd_req = 1'b1; rd_addr = AW'(DEPTH - 1);
      tick();
      check("top_rd_ack", 256'(rd_ack), 256'(1));
      rd_req = 1'b0;
      tick();
      check("top_rd_vld", 256'(rd_vld), 256'(1));
      check("top_rd_data", 256'(rd_data), 256'(0));
      tick();
      pred_w = 1'b0; pred_r = 1'b0; exp_vld = 1'b0;

      run_random(600);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
